dtube_scan_driver: RTL and testbench

Six-digit multiplexed 7-segment scan driver for the digital clock display. Sits directly downstream of the clock logic block and consumes its `number_BCD`, `DTube_en` and `Twinkle_en` outputs. It snapshots the BCD word once per frame, scans one digit per slot, and decodes BCD to active-low segments. It blanks disabled digit pairs and blinks edited digit pairs at a fixed rate. Runs on the same 1 kHz system clock.

---
 rtl/dtube_scan_driver.sv | 131 +++++++++++++
 tb/tb_dtube_scan_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtube_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver: per-frame BCD snapshot,
// active-low digit/segment drive, pair blanking and pair blinking.
module dtube_scan_driver #(
   parameter int SCAN_DIV   = 1,
   parameter int BLINK_HALF = 250
) (
   input  logic        clk,
   input  logic        rst_N,
   input  logic [23:0] number_BCD,
   input  logic [2:0]  DTube_en,
   input  logic [2:0]  Twinkle_en,
   output logic [5:0]  dig_N,
   output logic [7:0]  seg_N
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = $clog2(BLINK_HALF);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_HALF - 1);

   logic [DW-1:0] div_q, div_d;
   logic [2:0]    idx_q, idx_d;
   logic [23:0]   snap_q, snap_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic [2:0]    tw_q, tw_d;
   logic [5:0]    dig_q, dig_d;
   logic [7:0]    seg_q, seg_d;

   logic [1:0] pair;
   logic [3:0] nib;
   logic [6:0] seg7;
   logic       vis;
   logic       dp_n;
   logic       rise;

   always_comb begin
      div_d  = div_q;
      idx_d  = idx_q;
      snap_d = snap_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         if (idx_q == 3'd5) begin
            idx_d  = 3'd0;
            snap_d = number_BCD;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else begin
         div_d = div_q + DW'(1);
      end
   end

   // A rising blink request restarts the half-period with the field shown.
   always_comb begin
      rise    = |(Twinkle_en & ~tw_q);
      tw_d    = Twinkle_en;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (rise) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == BLK_LAST) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + BW'(1);
      end
   end

   always_comb begin
      pair = idx_q[2:1];
      case (idx_q)
         3'd0:    nib = snap_q[3:0];
         3'd1:    nib = snap_q[7:4];
         3'd2:    nib = snap_q[11:8];
         3'd3:    nib = snap_q[15:12];
         3'd4:    nib = snap_q[19:16];
         3'd5:    nib = snap_q[23:20];
         default: nib = 4'hF;
      endcase
      case (nib)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
      dp_n = ~((idx_q == 3'd2) || (idx_q == 3'd4));
      vis  = DTube_en[pair] & ~(Twinkle_en[pair] & ~phase_q);
      if (vis) begin
         dig_d = ~(6'b000001 << idx_q);
         seg_d = {dp_n, seg7};
      end else begin
         dig_d = 6'h3F;
         seg_d = 8'hFF;
      end
   end

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         div_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b1;
         tw_q    <= '0;
         dig_q   <= 6'h3F;
         seg_q   <= 8'hFF;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         tw_q    <= tw_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
      end
   end

   assign dig_N = dig_q;
   assign seg_N = seg_q;

endmodule

// File: tb/tb_dtube_scan_driver.sv
// Bench for dtube_scan_driver: two instances (SCAN_DIV 1 and 3) against an
// arithmetic reference model, plus directed literal checks.
module tb_dtube_scan_driver;

   logic        clk = 1'b0;
   logic        rst_N;
   logic [23:0] number_BCD;
   logic [2:0]  DTube_en;
   logic [2:0]  Twinkle_en;
   logic [5:0]  dig0, dig3;
   logic [7:0]  seg0, seg3;

   int errors;
   int checks;

   always #5 clk = ~clk;

   dtube_scan_driver #(.SCAN_DIV(1), .BLINK_HALF(250)) u0 (
      .clk(clk), .rst_N(rst_N), .number_BCD(number_BCD),
      .DTube_en(DTube_en), .Twinkle_en(Twinkle_en),
      .dig_N(dig0), .seg_N(seg0)
   );

   dtube_scan_driver #(.SCAN_DIV(3), .BLINK_HALF(5)) u3 (
      .clk(clk), .rst_N(rst_N), .number_BCD(number_BCD),
      .DTube_en(DTube_en), .Twinkle_en(Twinkle_en),
      .dig_N(dig3), .seg_N(seg3)
   );

   function automatic int sdv(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int bhv(int i);
      return (i == 0) ? 250 : 5;
   endfunction

   function automatic logic [6:0] dec7(logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // n = edges since reset, k = edge count at last blink restart
   function automatic logic [13:0] model_out(int i, int n, int k,
                                             logic [23:0] snap,
                                             logic [2:0] en,
                                             logic [2:0] tw);
      int idx;
      int p;
      bit on;
      logic [3:0] nib;
      logic [5:0] d;
      logic       dp;
      idx = (n / sdv(i)) % 6;
      p   = idx / 2;
      on  = (((n - k) / bhv(i)) % 2) == 0;
      nib = snap[idx*4 +: 4];
      d   = ~(6'b000001 << idx);
      dp  = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
      if (en[p] && !(tw[p] && !on)) return {d, dp, dec7(nib)};
      return {6'h3F, 8'hFF};
   endfunction

   int          mn[2];
   int          mk[2];
   logic [23:0] msnap[2];
   logic [2:0]  mtw[2];
   logic [13:0] mexp[2];

   always @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         for (int i = 0; i < 2; i++) begin
            mn[i]    <= 0;
            mk[i]    <= 0;
            msnap[i] <= '0;
            mtw[i]   <= '0;
            mexp[i]  <= {6'h3F, 8'hFF};
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            mexp[i] <= model_out(i, mn[i], mk[i], msnap[i],
                                 DTube_en, Twinkle_en);
            if ((mn[i] + 1) % (6 * sdv(i)) == 0) msnap[i] <= number_BCD;
            if ((Twinkle_en & ~mtw[i]) != 3'b000) mk[i] <= mn[i] + 1;
            mtw[i] <= Twinkle_en;
            mn[i]  <= mn[i] + 1;
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(string nm, int act, int lo, int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("u0_dig_model", int'(dig0), int'(mexp[0][13:8]));
      chk("u0_seg_model", int'(seg0), int'(mexp[0][7:0]));
      chk("u3_dig_model", int'(dig3), int'(mexp[1][13:8]));
      chk("u3_seg_model", int'(seg3), int'(mexp[1][7:0]));
   endtask

   initial begin
      int cnt_a;
      int cnt_b;
      int cnt_c;
      bit found;
      errors     = 0;
      checks     = 0;
      rst_N      = 1'b0;
      number_BCD = 24'($urandom);
      DTube_en   = 3'($urandom);
      Twinkle_en = 3'($urandom);
      repeat (3) tick();
      chk("rst_dig0", int'(dig0), 'h3F);
      chk("rst_seg0", int'(seg0), 'hFF);
      chk("rst_dig3", int'(dig3), 'h3F);
      chk("rst_seg3", int'(seg3), 'hFF);

      number_BCD = 24'h123456;
      DTube_en   = 3'b111;
      Twinkle_en = 3'b000;
      rst_N      = 1'b1;
      tick();
      chk("f0_d0_dig", int'(dig0), 'h3E);
      chk("f0_d0_seg", int'(seg0), 'hC0);
      repeat (2) tick();
      chk("f0_d2_dig", int'(dig0), 'h3B);
      chk("f0_d2_seg", int'(seg0), 'h40);
      repeat (4) tick();
      chk("f1_d0_dig", int'(dig0), 'h3E);
      chk("f1_d0_seg", int'(seg0), 'h82);
      repeat (4) tick();
      chk("f1_d4_dig", int'(dig0), 'h2F);
      chk("f1_d4_seg", int'(seg0), 'h24);
      tick();
      chk("f1_d5_dig", int'(dig0), 'h1F);
      chk("f1_d5_seg", int'(seg0), 'hF9);

      number_BCD = 24'h000000;
      repeat (12) tick();
      for (int w = 0; w < 6 && (mn[0] % 6) != 3; w++) tick();
      number_BCD = 24'h999999;
      tick();
      chk("snap_d3_dig", int'(dig0), 'h37);
      chk("snap_d3_seg", int'(seg0), 'hC0);
      tick();
      chk("snap_d4_dig", int'(dig0), 'h2F);
      chk("snap_d4_seg", int'(seg0), 'h40);
      tick();
      chk("snap_d5_seg", int'(seg0), 'hC0);
      tick();
      chk("snap_n0_dig", int'(dig0), 'h3E);
      chk("snap_n0_seg", int'(seg0), 'h90);
      tick();
      chk("snap_n1_seg", int'(seg0), 'h90);
      tick();
      chk("snap_n2_seg", int'(seg0), 'h10);

      DTube_en = 3'b110;
      cnt_a = 0;
      repeat (6) begin
         tick();
         if (dig0 == 6'h3F && seg0 == 8'hFF) cnt_a++;
      end
      chk("pair_blank_cnt", cnt_a, 2);

      DTube_en   = 3'b111;
      Twinkle_en = 3'b000;
      tick();
      Twinkle_en = 3'b010;
      tick();
      cnt_a = 0;
      cnt_b = 0;
      cnt_c = 0;
      repeat (250) begin
         tick();
         if (!dig0[2] || !dig0[3]) cnt_a++;
      end
      repeat (250) begin
         tick();
         if (!dig0[2] || !dig0[3]) cnt_b++;
         if (!dig0[4] || !dig0[5]) cnt_c++;
      end
      chk_rng("blink_on_min", cnt_a, 82, 84);
      chk("blink_off_min", cnt_b, 0);
      chk_rng("blink_off_hour", cnt_c, 82, 84);
      cnt_a = 0;
      repeat (6) begin
         tick();
         if (!dig0[2] || !dig0[3]) cnt_a++;
      end
      chk("blink_back_on", cnt_a, 2);

      found = 1'b0;
      for (int w = 0; w < 600 && !found; w++) begin
         if (((mn[0] - mk[0]) % 250) == 249) found = 1'b1;
         else tick();
      end
      chk("restart_wait", int'(found), 1);
      Twinkle_en = 3'b110;
      tick();
      cnt_a = 0;
      repeat (250) begin
         tick();
         if (dig0 == 6'h3F) cnt_a++;
      end
      chk("restart_on_window", cnt_a, 0);

      number_BCD = 24'h0000A0;
      Twinkle_en = 3'b000;
      DTube_en   = 3'b111;
      repeat (40) tick();
      cnt_a = 0;
      cnt_b = 0;
      repeat (18) begin
         tick();
         if (dig3 == 6'h3D) cnt_a++;
         if (dig3 == 6'h3D && seg3 == 8'hFF) cnt_b++;
      end
      chk("bad_bcd_hold", cnt_a, 3);
      chk("bad_bcd_blank", cnt_b, 3);

      repeat (3000) begin
         if ($urandom_range(0, 9) == 0) number_BCD = 24'($urandom);
         if ($urandom_range(0, 19) == 0) DTube_en = 3'($urandom);
         if ($urandom_range(0, 14) == 0) Twinkle_en = 3'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_N = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            rst_N = 1'b1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
